// File: rtl/rv32i_types.sv
// Shared RV32I core types and constants used by the fetch stage.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    localparam rv32i_word RESET_PC = 32'h0000_0060;

    // Byte distance between consecutive 32-bit instructions.
    localparam int PC_STEP = 4;

endpackage

// File: rtl/word_reg.sv
// WIDTH-bit register with synchronous clear (to RESET_VAL) and load enable.
module word_reg #(
    parameter int                 WIDTH     = 32,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, next-PC selection, and IF/ID stage register.
module fetch_stage
    import rv32i_types::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = rv32i_types::RESET_PC
) (
    input  logic             clk,
    input  logic             reset,
    output logic             read_a,
    output logic [WIDTH-1:0] address_a,
    input  logic [WIDTH-1:0] rdata_a,
    input  logic             resp_a,
    input  logic             resp_b,
    input  logic             stall_in,
    input  logic             pcmux_sel,
    input  logic [WIDTH-1:0] target_pc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] instruction
);

    logic             advance;
    logic             flush;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] next_pc;

    // Both memories must have answered and nothing downstream may be stalled.
    assign advance  = resp_a & resp_b & ~stall_in;
    assign flush    = reset | pcmux_sel;

    assign pc_plus4 = pc_q + WIDTH'(PC_STEP);
    assign next_pc  = pcmux_sel ? target_pc : pc_plus4;

    assign read_a    = 1'b1;
    assign address_a = pc_q;

    word_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .clear (reset),
        .load  (advance),
        .d     (next_pc),
        .q     (pc_q)
    );

    // A redirect bubbles IF/ID even when the PC itself cannot move yet.
    word_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL ('0)
    ) u_ifid_pc (
        .clk   (clk),
        .clear (flush),
        .load  (advance),
        .d     (pc_q),
        .q     (pc)
    );

    word_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL ('0)
    ) u_ifid_instr (
        .clk   (clk),
        .clear (flush),
        .load  (advance),
        .d     (rdata_a),
        .q     (instruction)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized bench for fetch_stage against a behavioural fetch model.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0060;

    logic        clk;
    logic        reset;
    logic        read_a;
    logic [31:0] address_a;
    logic [31:0] rdata_a;
    logic        resp_a;
    logic        resp_b;
    logic        stall_in;
    logic        pcmux_sel;
    logic [31:0] target_pc;
    logic [31:0] pc;
    logic [31:0] instruction;

    int passed = 0;
    int total  = 0;

    // Behavioural model: fetch pointer plus the last latched (pc, instruction) pair.
    logic [31:0] m_fetch;
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .read_a      (read_a),
        .address_a   (address_a),
        .rdata_a     (rdata_a),
        .resp_a      (resp_a),
        .resp_b      (resp_b),
        .stall_in    (stall_in),
        .pcmux_sel   (pcmux_sel),
        .target_pc   (target_pc),
        .pc          (pc),
        .instruction (instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_edge();
        bit moves;
        moves = resp_a && resp_b && !stall_in;
        if (reset) begin
            m_fetch = RST_PC;
            m_pc    = 32'h0;
            m_instr = 32'h0;
        end else begin
            if (pcmux_sel) begin
                m_pc    = 32'h0;
                m_instr = 32'h0;
            end else if (moves) begin
                m_pc    = m_fetch;
                m_instr = rdata_a;
            end
            if (moves) m_fetch = pcmux_sel ? target_pc : m_fetch + 32'd4;
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".address_a"},   address_a,   m_fetch);
        check({tag, ".pc"},          pc,          m_pc);
        check({tag, ".instruction"}, instruction, m_instr);
        check({tag, ".read_a"},      {31'h0, read_a}, 32'h1);
    endtask

    initial begin
        m_fetch   = 32'h0;
        m_pc      = 32'h0;
        m_instr   = 32'h0;
        reset     = 1'b1;
        resp_a    = 1'b1;
        resp_b    = 1'b1;
        stall_in  = 1'b0;
        pcmux_sel = 1'b0;
        target_pc = 32'h0;
        rdata_a   = 32'h0000_0013;

        cycle("reset0");
        cycle("reset1");
        check("reset.address_a",   address_a,   32'h60);
        check("reset.pc",          pc,          32'h0);
        check("reset.instruction", instruction, 32'h0);

        reset = 1'b0;
        cycle("seq0");
        check("seq0.addr", address_a, 32'h64);
        check("seq0.pc",   pc,        32'h60);
        check("seq0.ins",  instruction, 32'h13);

        stall_in = 1'b1;
        rdata_a  = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) cycle("stall");
        check("stall.addr", address_a,   32'h64);
        check("stall.pc",   pc,          32'h60);
        check("stall.ins",  instruction, 32'h13);

        stall_in = 1'b0;
        rdata_a  = 32'h0010_0093;
        cycle("resume");
        check("resume.addr", address_a,   32'h68);
        check("resume.pc",   pc,          32'h64);
        check("resume.ins",  instruction, 32'h0010_0093);

        resp_b = 1'b0;
        cycle("wait_b0");
        cycle("wait_b1");
        resp_a = 1'b0;
        resp_b = 1'b1;
        cycle("wait_a0");
        cycle("wait_a1");
        check("wait.addr", address_a, 32'h68);
        check("wait.pc",   pc,        32'h64);

        resp_a    = 1'b1;
        pcmux_sel = 1'b1;
        target_pc = 32'h200;
        cycle("redir");
        check("redir.addr", address_a,   32'h200);
        check("redir.pc",   pc,          32'h0);
        check("redir.ins",  instruction, 32'h0);
        pcmux_sel = 1'b0;
        rdata_a   = 32'h0000_0022;
        cycle("redir_next");
        check("redir_next.pc",  pc,          32'h200);
        check("redir_next.ins", instruction, 32'h22);

        stall_in  = 1'b1;
        pcmux_sel = 1'b1;
        target_pc = 32'h300;
        cycle("flush_stall");
        check("flush_stall.addr", address_a, 32'h204);
        check("flush_stall.pc",   pc,        32'h0);
        check("flush_stall.ins",  instruction, 32'h0);
        stall_in = 1'b0;
        cycle("flush_release");
        check("flush_release.addr", address_a, 32'h300);
        check("flush_release.pc",   pc,        32'h0);

        target_pc = 32'hFFFF_FFFC;
        cycle("wrap_redir");
        pcmux_sel = 1'b0;
        rdata_a   = 32'h0000_0055;
        cycle("wrap");
        check("wrap.addr", address_a, 32'h0);
        check("wrap.pc",   pc,        32'hFFFF_FFFC);

        reset     = 1'b1;
        pcmux_sel = 1'b1;
        target_pc = 32'h400;
        cycle("rst_prio");
        check("rst_prio.addr", address_a, 32'h60);
        check("rst_prio.pc",   pc,        32'h0);
        reset     = 1'b0;
        pcmux_sel = 1'b0;

        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 39) == 0);
            resp_a    = ($urandom_range(0, 3) != 0);
            resp_b    = ($urandom_range(0, 3) != 0);
            stall_in  = ($urandom_range(0, 4) == 0);
            pcmux_sel = ($urandom_range(0, 7) == 0);
            target_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            rdata_a   = $urandom();
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
